// File: rtl/dds_skew_wave.sv
// Time-multiplexed skewed-triangle generator: one shared multiplier sweeps all
// channels per Sync and publishes every channel's sample on the same edge.
module dds_skew_wave #(
    parameter int n = 12
) (
    input  logic            Clk,
    input  logic            nReset,
    input  logic            Sync,
    input  logic [32*n-1:0] Freq,
    input  logic [18*n-1:0] Skew,
    input  logic [18*n-1:0] InvRise,
    input  logic [18*n-1:0] InvFall,
    output logic [18*n-1:0] Wave,
    output logic            Valid,
    output logic            Busy,
    output logic            Overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_MUL,
        S_STORE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      ch_q, ch_d;
    logic [31:0]     phase_q [n];
    logic [17:0]     shadow_q [n];
    logic [17:0]     a_q, a_d;
    logic [17:0]     b_q, b_d;
    logic [35:0]     prod_q;
    logic [18*n-1:0] wave_q;
    logic            valid_q;
    logic            overrun_q;

    logic [31:0]     freq_c;
    logic [31:0]     phase_c;
    logic [31:0]     phase_new;
    logic [17:0]     skew_c;
    logic [17:0]     rise_c;
    logic [17:0]     fall_c;
    logic [17:0]     p;
    logic [17:0]     u;

    // Select the active channel's inputs and phase; only ACC consumes them.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        freq_c  = '0;
        phase_c = '0;
        skew_c  = '0;
        rise_c  = '0;
        fall_c  = '0;
        for (int c = 0; c < n; c++) begin
            if (ch_q == 4'(c)) begin
                freq_c  = Freq[32*c +: 32];
                phase_c = phase_q[c];
                skew_c  = Skew[18*c +: 18];
                rise_c  = InvRise[18*c +: 18];
                fall_c  = InvFall[18*c +: 18];
            end
        end
    end

    assign phase_new = phase_c + freq_c;
    assign p         = phase_new[31:14];

    // P == Skew belongs to the falling segment; there P >= 1 so 2^18-P fits 18 bits.
    always_comb begin
        if (p < skew_c) begin
            a_d = p;
            b_d = rise_c;
        end else begin
            a_d = 18'd0 - p;
            b_d = fall_c;
        end
    end

    assign u = (|prod_q[35:27]) ? 18'h3FFFF : prod_q[26:9];

    // State register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: begin
                if (Sync) begin
                    state_d = S_ACC;
                    ch_d    = '0;
                end
            end
            S_ACC:   state_d = S_MUL;
            S_MUL:   state_d = S_STORE;
            S_STORE: begin
                if (ch_q == 4'(n-1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 4'd1;
                    state_d = S_ACC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ch_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                ch_d    = '0;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        Busy = (state_q == S_ACC) || (state_q == S_MUL) || (state_q == S_STORE);
    end

    // Datapath; a reset mid-sweep clears the shadow so no partial sweep can surface.
    // NOTE: the per-channel arrays are reset because the spec requires phase 0 after reset.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int c = 0; c < n; c++) begin
                phase_q[c]  <= '0;
                shadow_q[c] <= '0;
            end
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            wave_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= (state_q == S_DONE);
            overrun_q <= Sync && (state_q != S_IDLE);
            if (state_q == S_ACC) begin
                for (int c = 0; c < n; c++) begin
                    if (ch_q == 4'(c)) phase_q[c] <= phase_new;
                end
                a_q <= a_d;
                b_q <= b_d;
            end
            if (state_q == S_MUL) begin
                prod_q <= 36'(a_q) * 36'(b_q);
            end
            if (state_q == S_STORE) begin
                for (int c = 0; c < n; c++) begin
                    if (ch_q == 4'(c)) shadow_q[c] <= {~u[17], u[16:0]};
                end
            end
            if (state_q == S_DONE) begin
                for (int c = 0; c < n; c++) begin
                    wave_q[18*c +: 18] <= shadow_q[c];
                end
            end
        end
    end

    assign Wave    = wave_q;
    assign Valid   = valid_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_dds_skew_wave.sv
// Directed bench for dds_skew_wave: hand-computed samples plus a per-channel
// arithmetic model of the skewed triangle for the multi-channel sweeps.
module tb_dds_skew_wave;

    localparam int N = 12;

    logic            Clk = 1'b0;
    logic            nReset = 1'b0;
    logic            Sync = 1'b0;
    logic [32*N-1:0] Freq;
    logic [18*N-1:0] Skew;
    logic [18*N-1:0] InvRise;
    logic [18*N-1:0] InvFall;
    logic [18*N-1:0] Wave;
    logic            Valid;
    logic            Busy;
    logic            Overrun;

    int              total = 0;
    int              bad = 0;
    logic [31:0]     ph [N];
    logic [18*N-1:0] exp_wave;

    always #5 Clk = ~Clk;

    dds_skew_wave #(.n(N)) dut (
        .Clk     (Clk),
        .nReset  (nReset),
        .Sync    (Sync),
        .Freq    (Freq),
        .Skew    (Skew),
        .InvRise (InvRise),
        .InvFall (InvFall),
        .Wave    (Wave),
        .Valid   (Valid),
        .Busy    (Busy),
        .Overrun (Overrun)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] ref_sample(input logic [31:0] phase, input logic [17:0] sk,
                                               input logic [17:0] ir, input logic [17:0] ifl);
        logic [17:0] pp;
        logic [17:0] a;
        logic [17:0] b;
        logic [35:0] pr;
        logic [17:0] uu;
        pp = phase[31:14];
        if (pp < sk) begin
            a = pp;
            b = ir;
        end else begin
            a = 18'(19'h40000 - {1'b0, pp});
            b = ifl;
        end
        pr = 36'(a) * 36'(b);
        uu = (pr >= 36'h8000000) ? 18'h3FFFF : pr[26:9];
        return {~uu[17], uu[16:0]};
    endfunction

    function automatic logic [18*N-1:0] model_wave();
        logic [18*N-1:0] w;
        w = '0;
        for (int c = 0; c < N; c++) begin
            w[18*c +: 18] = ref_sample(ph[c], Skew[18*c +: 18], InvRise[18*c +: 18], InvFall[18*c +: 18]);
        end
        return w;
    endfunction

    function automatic logic [17:0] inv_const(input logic [18:0] s);
        return 18'((32'h07FF_FFFF) / 32'(s));
    endfunction

    task automatic model_advance();
        for (int c = 0; c < N; c++) ph[c] = ph[c] + Freq[32*c +: 32];
        exp_wave = model_wave();
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) ph[c] = '0;
        exp_wave = '0;
    endtask

    // Pulses Sync for one edge, then waits (bounded) for Valid; pre is Wave one cycle before Valid.
    task automatic pulse_sync(output int lat, output logic [18*N-1:0] pre);
        Sync = 1'b1;
        @(posedge Clk); #1;
        Sync = 1'b0;
        lat = 0;
        pre = Wave;
        while (!Valid && lat < 100) begin
            pre = Wave;
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic sync_step(input string tag);
        int              lat;
        logic [18*N-1:0] pre;
        pulse_sync(lat, pre);
        check({tag, " latency"}, 256'(lat), 256'(37));
        check({tag, " hold"}, 256'(pre), 256'(exp_wave));
        model_advance();
        check({tag, " wave"}, 256'(Wave), 256'(exp_wave));
        check({tag, " busy_low"}, 256'(Busy), 256'(0));
    endtask

    task automatic do_reset(input string tag);
        nReset = 1'b0;
        #1;
        check({tag, " wave"}, 256'(Wave), 256'(0));
        check({tag, " busy"}, 256'(Busy), 256'(0));
        check({tag, " valid"}, 256'(Valid), 256'(0));
        check({tag, " overrun"}, 256'(Overrun), 256'(0));
        repeat (2) @(posedge Clk);
        #1;
        nReset = 1'b1;
        model_reset();
    endtask

    task automatic set_defaults();
        for (int c = 0; c < N; c++) begin
            Freq[32*c +: 32]    = 32'h0;
            Skew[18*c +: 18]    = 18'h20000;
            InvRise[18*c +: 18] = 18'h003FF;
            InvFall[18*c +: 18] = 18'h003FF;
        end
    endtask

    initial begin
        int vcnt;
        set_defaults();
        model_reset();
        @(posedge Clk); #1;
        do_reset("reset");

        // Frozen phases: every channel sits at P=0 on the rising edge -> 0x20000.
        for (int i = 0; i < 3; i++) sync_step("freq0");
        check("freq0 all mid", 256'(Wave), 256'({N{18'h20000}}));

        // Channel 0 ramps through a full period in 64 Syncs.
        Freq[31:0] = 32'h0400_0000;
        sync_step("ramp1");
        check("ramp P=0x1000", 256'(Wave[17:0]), 256'(18'h21FF8));
        check("ramp ch1 held", 256'(Wave[35:18]), 256'(18'h20000));
        repeat (15) sync_step("ramp");
        check("ramp P=0x10000", 256'(Wave[17:0]), 256'(18'h3FF80));
        repeat (16) sync_step("ramp");
        check("ramp P=skew fall", 256'(Wave[17:0]), 256'(18'h1FF00));
        repeat (16) sync_step("ramp");
        check("ramp P=0x30000", 256'(Wave[17:0]), 256'(18'h3FF80));
        repeat (16) sync_step("ramp");
        check("ramp wrap", 256'(Wave[17:0]), 256'(18'h20000));

        // Saturation on channel 3.
        Freq[31:0]     = 32'h0;
        Freq[127:96]   = 32'h8000_0000;
        Skew[71:54]    = 18'h3FFFF;
        InvRise[71:54] = 18'h3FFFF;
        sync_step("sat");
        check("sat ch3", 256'(Wave[71:54]), 256'(18'h1FFFF));
        set_defaults();

        // Sync during a sweep is dropped and flagged.
        do_reset("reset2");
        Freq[31:0] = 32'h0400_0000;
        Sync = 1'b1;
        @(posedge Clk); #1;
        Sync = 1'b0;
        check("ovr busy", 256'(Busy), 256'(1));
        repeat (9) @(posedge Clk);
        #1;
        Sync = 1'b1;
        @(posedge Clk); #1;
        Sync = 1'b0;
        check("ovr pulse", 256'(Overrun), 256'(1));
        @(posedge Clk); #1;
        check("ovr one cycle", 256'(Overrun), 256'(0));
        vcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge Clk); #1;
            if (Valid) vcnt++;
        end
        check("ovr valid count", 256'(vcnt), 256'(1));
        model_advance();
        check("ovr wave", 256'(Wave), 256'(exp_wave));
        check("ovr ch0 once", 256'(Wave[17:0]), 256'(18'h21FF8));
        sync_step("ovr next");
        check("ovr ch0 twice", 256'(Wave[17:0]), 256'(18'h23FF0));

        // Reset in the middle of a sweep.
        Sync = 1'b1;
        @(posedge Clk); #1;
        Sync = 1'b0;
        repeat (19) @(posedge Clk);
        #1;
        check("abort busy pre", 256'(Busy), 256'(1));
        do_reset("abort");
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge Clk); #1;
            if (Valid) vcnt++;
        end
        check("abort no valid", 256'(vcnt), 256'(0));
        check("abort wave zero", 256'(Wave), 256'(0));
        sync_step("restart");
        check("restart ch0", 256'(Wave[17:0]), 256'(18'h21FF8));

        // All channels with distinct rates and breakpoints.
        for (int c = 0; c < N; c++) begin
            logic [17:0] sk;
            sk = 18'h01000 + 18'(c * 32'h3000);
            Freq[32*c +: 32]    = 32'(32'h0913_5A27 * (c + 1));
            Skew[18*c +: 18]    = sk;
            InvRise[18*c +: 18] = inv_const({1'b0, sk});
            InvFall[18*c +: 18] = inv_const(19'h40000 - {1'b0, sk});
        end
        for (int i = 0; i < 4; i++) sync_step("multi");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_skew_wave.md
Name: dds_skew_wave

Overview:
- Time-multiplexed n-channel skewed-triangle (sawtooth-to-triangle) waveform generator.
- Sits directly downstream of the DDS constants stage and consumes its per-channel slope constants Skew, 1/Skew and 1/(2^18-Skew).
- Each Sync strobe advances every channel's 32-bit phase accumulator once, computes one 18-bit signed sample per channel with a single shared multiplier, and publishes all n samples together.

Parameters:
- n, 12, number of channels (1..16); channel counter is 4 bits.

Ports:
- Clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- Sync  in  1  sample strobe; one sample per channel per accepted pulse.
- Freq  in  32*n  per-channel phase increment, channel c at [32c+31:32c].
- Skew  in  18*n  per-channel breakpoint, unsigned 0.18 fraction of period, never 0 (from Y1).
- InvRise  in  18*n  per-channel rising-slope constant, largest q with Skew*q < 2^27 (from Y2).
- InvFall  in  18*n  per-channel falling-slope constant, largest q with (2^18-Skew)*q < 2^27 (from Y3).
- Wave  out  18*n  per-channel sample, two's complement, channel c at [18c+17:18c].
- Valid  out  1  one-cycle pulse when Wave updates.
- Busy  out  1  high while a sample sweep is in progress.
- Overrun  out  1  one-cycle pulse when Sync arrives while Busy.

Behaviour:
- Reset (async, nReset low): all phase accumulators = 0, shadow and Wave = 0, Valid = Busy = Overrun = 0, channel = 0, state = IDLE.
- Reset asserted mid-sweep aborts the sweep. No partial results reach Wave.
- States:
  - IDLE: if Sync, go to ACC, channel=0, Busy=1.
  - ACC:
    - Phase[c] <= Phase[c] + Freq[c] (mod 2^32).
    - P = new Phase[c][31:14] (18 bits).
    - If P < Skew[c]: rising, latch A=P, B=InvRise[c].
    - Else: falling, latch A = 2^18 - P (18 bits, P>=1 here), B=InvFall[c].
    - Go to MUL.
  - MUL: register 36-bit unsigned product A*B. Go to STORE.
  - STORE:
    - U = |prod[35:27] ? 18'h3FFFF : prod[26:9].
    - shadow[c] = {~U[17], U[16:0]}.
    - If c == n-1: go to DONE. Else c+1, go to ACC.
  - DONE: Wave <= shadow (all channels at once), Valid=1 for this cycle, Busy=0, channel=0, go to IDLE.
- Latency and throughput:
  - Sync sampled at edge k produces Wave/Valid at edge k+3n+1.
  - Busy is high from edge k+1 through k+3n.
  - Minimum Sync spacing is 3n+2 cycles (38 for n=12).
- Sync handling:
  - Sync while not IDLE is ignored and pulses Overrun on the next edge. Phases do not advance for the dropped sample.
  - Sync high in the same cycle as DONE is also dropped with Overrun.
  - Sync held high re-triggers from each IDLE cycle.
- Inputs Freq, Skew, InvRise and InvFall are sampled only in ACC for the channel being processed. Changes mid-sweep apply to later channels.
- Boundary cases:
  - P == Skew selects falling.
  - Freq = 0 holds phase and repeats the same sample.
  - Phase wrap is natural modulo 2^32.
  - Saturation clamps U to 0x3FFFF (Wave 0x1FFFF).
- Wave changes only in DONE. Between updates it holds its value.

Test Plan:
- Reset, then 3 Syncs with all Freq=0, Skew=0x20000, InvRise=InvFall=0x3FF -> each Valid pulse exactly 37 cycles after its Sync; every Wave channel = 0x20000 (P=0, U=0).
- ch0 Freq=0x0400_0000, Skew=0x20000, InvRise=InvFall=0x3FF, one Sync -> Wave[17:0]=0x21FF8 (P=0x1000, U=0x1FF8). After 16 Syncs -> P=0x10000, Wave=0x3FF80. After 32 Syncs -> P=0x20000 falling, Wave=0x1FF00. After 48 Syncs -> P=0x30000, Wave=0x3FF80. After 64 Syncs -> phase wraps to 0, Wave=0x20000.
- Saturation: ch3 Freq=0x8000_0000, Skew=0x3FFFF, InvRise=0x3FFFF -> after one Sync P=0x20000 rising, product overflows, Wave[71:54]=0x1FFFF.
- Sync pulsed 10 cycles after a previous Sync -> Overrun pulses once, Valid count is 1, phases advanced only once.
- nReset asserted at cycle 20 of a sweep (n=12) -> Busy=0, Valid never pulses. Wave stays 0; next Sync restarts from phase 0 and gives first-sample values as in scenario 2.
- All 12 channels with distinct Freq/Skew -> each channel matches the reference model; Wave channels all change on the same edge.
